// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scans NUM_DIGITS hex codes onto one 7-segment bus; outputs registered one cycle after scan state.
// digits_ready stays low while an update waits for the frame boundary; SEG7_SCAN_DP_EN adds decimal points.
module seg7_scan_mux #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [23:0] REFRESH_DIV  = 24'd10_000,
    parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    digits_valid,
    output logic                    digits_ready,
    input  logic                    blank_lz,
`ifdef SEG7_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int              SW         = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0]   LAST_SLOT  = SW'(NUM_DIGITS - 1);
    localparam logic [23:0]     PRESC_LAST = REFRESH_DIV - 24'd1;

    logic [23:0]             r_presc;
    logic [SW-1:0]           r_slot;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_full;
    logic [6:0]              r_segments;
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic                    r_frame_start;

    logic                    w_accept;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_blank_win;
    logic                    w_cur_lz;
    logic                    w_zero_run;
    logic [3:0]              w_cur_digit;
    logic [NUM_DIGITS-1:0]   w_slot_hot;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_dp_active;

    function automatic logic [6:0] hex_decode(input logic [3:0] code);
        case (code)
            4'h0:    hex_decode = 7'b0111111;
            4'h1:    hex_decode = 7'b0000110;
            4'h2:    hex_decode = 7'b1011011;
            4'h3:    hex_decode = 7'b1001111;
            4'h4:    hex_decode = 7'b1100110;
            4'h5:    hex_decode = 7'b1101101;
            4'h6:    hex_decode = 7'b1111101;
            4'h7:    hex_decode = 7'b0000111;
            4'h8:    hex_decode = 7'b1111111;
            4'h9:    hex_decode = 7'b1101111;
            4'hA:    hex_decode = 7'b1110111;
            4'hB:    hex_decode = 7'b1111100;
            4'hC:    hex_decode = 7'b0111001;
            4'hD:    hex_decode = 7'b1011110;
            4'hE:    hex_decode = 7'b1111001;
            default: hex_decode = 7'b1110001;
        endcase
    endfunction

    assign digits_ready = !r_pend_full && !reset;
    assign w_accept     = digits_valid && digits_ready;
    assign w_slot_end   = (r_presc == PRESC_LAST);
    assign w_frame_end  = w_slot_end && (r_slot == LAST_SLOT);
    assign w_blank_win  = (r_presc < {16'd0, BLANK_CYCLES});

    // Leading-zero run is evaluated from the top digit down; a set dp bit ends the run.
    always_comb begin
        w_zero_run  = 1'b1;
        w_lz_blank  = '0;
        w_slot_hot  = '0;
        w_cur_digit = 4'd0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run    = w_zero_run && (r_active[4*k +: 4] == 4'd0) && !w_dp_active[k];
            w_lz_blank[k] = blank_lz && (k != 0) && w_zero_run;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_slot == SW'(k)) begin
                w_slot_hot[k] = 1'b1;
                w_cur_digit   = r_active[4*k +: 4];
            end
        end
    end

    assign w_cur_lz = |(w_lz_blank & w_slot_hot);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_slot      <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_slot  <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
            end else begin
                r_presc <= r_presc + 24'd1;
            end
            // Transfer only at the frame boundary; pending is full then, so no accept can collide.
            if (w_frame_end && r_pend_full) begin
                r_active    <= r_pending;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pending   <= digits_in;
                r_pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_segments    <= '0;
            r_digit_sel   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= (r_presc == 24'd0) && (r_slot == '0);
            if (w_blank_win || w_cur_lz) begin
                r_segments  <= '0;
                r_digit_sel <= '0;
            end else begin
                r_segments  <= hex_decode(w_cur_digit);
                r_digit_sel <= w_slot_hot;
            end
        end
    end

`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic                  r_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_dp   <= '0;
            r_active_dp <= '0;
            r_dp        <= 1'b0;
        end else begin
            if (w_frame_end && r_pend_full) begin
                r_active_dp <= r_pend_dp;
            end else if (w_accept) begin
                r_pend_dp <= dp_in;
            end
            r_dp <= (w_blank_win || w_cur_lz) ? 1'b0 : |(r_active_dp & w_slot_hot);
        end
    end

    assign w_dp_active = r_active_dp;
    assign dp          = r_dp;
`else
    assign w_dp_active = '0;
`endif

    assign segments    = r_segments;
    assign digit_sel   = r_digit_sel;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (4 digits, 8-cycle slots, 2 blank cycles); expectations keyed by cycle.
`timescale 1ns/1ps
module tb_seg7_scan_mux;
    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        digits_valid = 1'b0;
    logic        blank_lz     = 1'b0;
    logic [15:0] digits_in    = '0;
    logic        digits_ready;
    logic        frame_start;
    logic [6:0]  segments;
    logic [3:0]  digit_sel;
`ifdef SEG7_SCAN_DP_EN
    logic [3:0]  dp_in = '0;
    logic        dp;
`endif

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        int          cyc;
        logic [63:0] tag;
        logic [3:0]  mask;
        logic [6:0]  seg;
        logic [3:0]  sel;
        logic        fs;
        logic        rdy;
        logic        dpv;
    } exp_t;

    exp_t sb[$];

    seg7_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (24'd8),
        .BLANK_CYCLES(8'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .digits_valid(digits_valid),
        .digits_ready(digits_ready),
        .blank_lz    (blank_lz),
`ifdef SEG7_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp          (dp),
`endif
        .segments    (segments),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mask: bit0 segments(+dp), bit1 digit_sel, bit2 frame_start, bit3 digits_ready
    function automatic void push(input int c, input logic [63:0] tag, input logic [3:0] mask,
                                 input logic [6:0] seg, input logic [3:0] sel, input logic fs,
                                 input logic rdy, input logic dpv);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.tag  = tag;
        e.mask = mask;
        e.seg  = seg;
        e.sel  = sel;
        e.fs   = fs;
        e.rdy  = rdy;
        e.dpv  = dpv;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endfunction

    function automatic void push_out(input int c, input logic [63:0] tag, input logic [6:0] seg,
                                     input logic [3:0] sel, input logic fs);
        push(c, tag, 4'b0111, seg, sel, fs, 1'b0, 1'b0);
    endfunction

    function automatic void push_rdy(input int c, input logic [63:0] tag, input logic rdy);
        push(c, tag, 4'b1000, 7'd0, 4'd0, 1'b0, rdy, 1'b0);
    endfunction

    // One full frame starting at output cycle c0: each slot is dark for 2 cycles, then lit if lit[s].
    function automatic void push_frame(input int c0, input logic [63:0] tag,
                                       input logic [6:0] s0, input logic [6:0] s1,
                                       input logic [6:0] s2, input logic [6:0] s3,
                                       input logic [3:0] lit, input logic [3:0] dpm);
        logic [3:0][6:0] segs;
        logic            on;
        segs = {s3, s2, s1, s0};
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 8; p++) begin
                on = (p >= 2) && lit[s];
                push(c0 + s*8 + p, tag, 4'b0111, on ? segs[s] : 7'd0, on ? 4'(1 << s) : 4'd0,
                     (s == 0 && p == 0), 1'b0, on ? dpm[s] : 1'b0);
            end
        end
    endfunction

    function automatic void check(input logic [63:0] tag, input string field, input int c,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %0s.%0s @cyc %0d: got %0h, expected %0h", tag, field, c, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %0s missed @cyc %0d", e.tag, e.cyc);
            end else begin
                if (e.mask[0]) check(e.tag, "seg", cyc, 32'(segments), 32'(e.seg));
                if (e.mask[1]) check(e.tag, "sel", cyc, 32'(digit_sel), 32'(e.sel));
                if (e.mask[2]) check(e.tag, "fs", cyc, 32'(frame_start), 32'(e.fs));
                if (e.mask[3]) check(e.tag, "rdy", cyc, 32'(digits_ready), 32'(e.rdy));
`ifdef SEG7_SCAN_DP_EN
                if (e.mask[0]) check(e.tag, "dp", cyc, 32'(dp), 32'(e.dpv));
`endif
            end
        end
        if (cyc >= 215 && cyc <= 414)
            check("t5_1hot", "sel", cyc, 32'($countones(digit_sel) <= 1), 32'd1);
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset and first load: 1234 accepted at edge 3, shown in frame starting cycle 35.
        push_out(1, "rst", 7'd0, 4'd0, 1'b0);
        push_rdy(1, "rst", 1'b0);
        push_out(2, "rst2", 7'd0, 4'd0, 1'b0);
        push_rdy(2, "rdy_up", 1'b1);
        push_out(3, "fs_first", 7'd0, 4'd0, 1'b1);
        push_rdy(3, "rdy_drop", 1'b0);
        push_out(5, "f0_s0", 7'b0111111, 4'b0001, 1'b0);
        push_rdy(33, "t1_hold", 1'b0);
        push_rdy(34, "t1_free", 1'b1);
        push_rdy(35, "t2_acc", 1'b0);
        push_frame(35, "t1", 7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 4'b1111, 4'b0000);
        goto(2);
        reset        = 1'b0;
        digits_valid = 1'b1;
        digits_in    = 16'h1234;
        goto(3);
        digits_valid = 1'b0;

        goto(34);
        blank_lz     = 1'b1;
        digits_valid = 1'b1;
        digits_in    = 16'h0070;
        push_frame(67, "t2a", 7'b0111111, 7'b0000111, 7'd0, 7'd0, 4'b0011, 4'b0000);
        goto(35);
        digits_valid = 1'b0;

        goto(66);
        digits_valid = 1'b1;
        digits_in    = 16'h0000;
        push_frame(99, "t2b", 7'b0111111, 7'd0, 7'd0, 7'd0, 4'b0001, 4'b0000);
        goto(67);
        digits_valid = 1'b0;

        // Mid-frame accept; a second word held on valid must wait for the boundary.
        goto(105);
        digits_valid = 1'b1;
        digits_in    = 16'h1111;
        push_rdy(105, "t3_pre", 1'b1);
        push_rdy(106, "t3_acc", 1'b0);
        push_rdy(129, "t3_held", 1'b0);
        push_rdy(130, "t3_bnd", 1'b1);
        push_rdy(131, "t3_acc2", 1'b0);
        push_frame(131, "t3_new", 7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 4'b1111, 4'b0000);
        push_frame(163, "t3_2nd", 7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011, 4'b1111, 4'b0000);
        goto(106);
        digits_in    = 16'h2222;
        goto(130);
        blank_lz     = 1'b0;
        goto(131);
        digits_valid = 1'b0;
        push_out(197, "t4_pre", 7'b1011011, 4'b0001, 1'b0);

        // Load 3333 into pending, then reset mid-slot2: pending and active both lost.
        goto(200);
        digits_valid = 1'b1;
        digits_in    = 16'h3333;
        push_rdy(200, "t4_rdy", 1'b1);
        push_rdy(201, "t4_acc", 1'b0);
        push_rdy(212, "t4_full", 1'b0);
        push_rdy(213, "t4_inrst", 1'b0);
        push_rdy(214, "t4_after", 1'b1);
        push_out(213, "t4_lit", 7'b1011011, 4'b0100, 1'b0);
        push_out(214, "t4_rst", 7'd0, 4'd0, 1'b0);
        push_frame(215, "t4_f0", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 4'b1111, 4'b0000);
        push_frame(247, "t4_f1", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 4'b1111, 4'b0000);
        for (int c = 215; c <= 414; c++)
            push(c, "t5_fs", 4'b0100, 7'd0, 4'd0, ((c - 215) % 32 == 0), 1'b0, 1'b0);
        goto(201);
        digits_valid = 1'b0;
        goto(213);
        reset = 1'b1;
        goto(214);
        reset = 1'b0;

`ifdef SEG7_SCAN_DP_EN
        goto(420);
        blank_lz     = 1'b1;
        digits_valid = 1'b1;
        digits_in    = 16'h0005;
        dp_in        = 4'b0010;
        push_frame(439, "t6_dp", 7'b1101101, 7'b0111111, 7'd0, 7'd0, 4'b0011, 4'b0010);
        goto(421);
        digits_valid = 1'b0;
        dp_in        = 4'b0000;
`endif

        goto(475);
        while (sb.size() > 0 && cyc < 600) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d expectations never reached", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
